// File: rtl/acc_bank_fl.sv
// acc_bank_fl -- bank of NACC floating-format accumulator channels.
//
// Each accepted operation commits one word into the selected channel, either
// on the accepting edge (single-cycle op or clear) or MCLAT clocks later
// (multicycle op). Before it is stored the word is passed through a small
// filter: clear -> 0, zero mantissa -> canonical 0, force-positive -> sign
// bit cleared.
//
// Word format: {sign[W-1], expo[W-2:NBMANT], mant[NBMANT-1:0]}.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   op_valid/ready  operation handshake (ready only while idle)
//   op_sel          target channel
//   op_data         word to commit
//   op_mc           multicycle operation
//   op_neg          force-positive (clear sign bit)
//   op_clr          clear target channel (wins over op_mc)
//   rd_sel/rd_data  combinational read port, no write bypass
//   wr_data         value committed on the current edge, 0 if none
//   acc_lsb         wr_data[0], used as branch flag
//   res_valid       one-cycle pulse after every commit
//   busy            FSM not idle
module acc_bank_fl #(
   parameter  int NBMANT = 16,
   parameter  int NBEXPO = 6,
   parameter  int NACC   = 4,
   parameter  int MCLAT  = 3,
   localparam int W      = NBMANT + NBEXPO + 1,
   localparam int SW     = $clog2(NACC)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          op_valid,
   output logic          op_ready,
   input  logic [SW-1:0] op_sel,
   input  logic [W-1:0]  op_data,
   input  logic          op_mc,
   input  logic          op_neg,
   input  logic          op_clr,
   input  logic [SW-1:0] rd_sel,
   output logic [W-1:0]  rd_data,
   output logic [W-1:0]  wr_data,
   output logic          acc_lsb,
   output logic          res_valid,
   output logic          busy
);

   localparam int CW = $clog2(MCLAT + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t                  state;
   logic [CW-1:0]           cnt;
   logic [SW-1:0]           sel_q;
   logic [W-1:0]            data_q;
   logic                    neg_q;
   logic [NACC-1:0][W-1:0]  bank;

   logic                    accept;
   logic                    acc_sc;
   logic                    acc_mc;
   logic                    commit_now;
   logic [SW-1:0]           cm_sel;
   logic [W-1:0]            cm_val;

   // Commit filter; the order of the tests matters (clear, then zero, then sign).
   function automatic logic [W-1:0] filt(input logic [W-1:0] x,
                                         input logic clr,
                                         input logic neg);
      logic [W-1:0] r;
      if (clr)
         r = '0;
      else if (x[NBMANT-1:0] == '0)
         r = '0;
      else if (neg)
         r = {1'b0, x[W-2:0]};
      else
         r = x;
      return r;
   endfunction

   assign op_ready = (state == IDLE);
   assign busy     = (state != IDLE);
   assign accept   = op_valid && op_ready;
   // A clear is always single-cycle, even when flagged multicycle.
   assign acc_sc   = accept && (!op_mc || op_clr);
   assign acc_mc   = accept && op_mc && !op_clr;

   // Commit source mux. Reset suppresses any commit on the same edge, so
   // wr_data must not advertise one either.
   always_comb begin
      commit_now = 1'b0;
      cm_sel     = op_sel;
      cm_val     = '0;
      if (!rst) begin
         if (acc_sc) begin
            commit_now = 1'b1;
            cm_sel     = op_sel;
            cm_val     = filt(op_data, op_clr, op_neg);
         end else if (state == COMMIT) begin
            commit_now = 1'b1;
            cm_sel     = sel_q;
            cm_val     = filt(data_q, 1'b0, neg_q);
         end
      end
   end

   assign wr_data = cm_val;
   assign acc_lsb = cm_val[0];

   // Per-channel storage; an out-of-range select matches no channel, so the
   // write is simply dropped.
   for (genvar i = 0; i < NACC; i++) begin : g_ch
      always_ff @(posedge clk) begin
         if (rst)
            bank[i] <= '0;
         else if (commit_now && (cm_sel == SW'(i)))
            bank[i] <= cm_val;
      end
   end

   // Read port returns 0 for selects past the last channel.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NACC; i++)
         if (rd_sel == SW'(i))
            rd_data = bank[i];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         res_valid <= 1'b0;
         sel_q     <= '0;
         data_q    <= '0;
         neg_q     <= 1'b0;
      end else begin
         res_valid <= commit_now;
         case (state)
            IDLE: begin
               if (acc_mc) begin
                  sel_q  <= op_sel;
                  data_q <= op_data;
                  neg_q  <= op_neg;
                  cnt    <= CW'(MCLAT - 1);
                  state  <= WAIT;
               end
            end
            WAIT: begin
               // Leaving at cnt==1 puts the commit edge MCLAT clocks after accept.
               cnt <= cnt - CW'(1);
               if (cnt <= CW'(1))
                  state <= COMMIT;
            end
            COMMIT:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/acc_bank_fl.md
ACC_BANK_FL -- requirements
Module: acc_bank_fl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NBMANT, 16, mantissa bits.
- NBEXPO, 6, exponent bits.
- NACC, 4, number of accumulator channels (≥2).
- MCLAT, 3, multicycle commit latency in clocks (≥2).
- W, NBMANT+NBEXPO+1, word width; derived, not overridable.
- SW, $clog2(NACC), channel-select width; derived, not overridable.

REQ-002 Word format is {sign[W-1], expo[W-2:NBMANT], mant[NBMANT-1:0]}.

REQ-003 Ports, one per line: name, direction, width, meaning. Clock and reset come first.
- clk, in, 1, single clock; all state changes on its rising edge.
- rst, in, 1, synchronous, active-high reset.
- op_valid, in, 1, operation request.
- op_ready, out, 1, unit can accept an operation.
- op_sel, in, SW, target channel.
- op_data, in, W, ALU result to commit.
- op_mc, in, 1, multicycle operation.
- op_neg, in, 1, force-positive mode: clear the sign bit.
- op_clr, in, 1, clear the target channel.
- rd_sel, in, SW, read channel select.
- rd_data, out, W, combinational value of channel rd_sel.
- wr_data, out, W, combinational value committed this cycle.
- acc_lsb, out, 1, wr_data[0]; used as the branch flag.
- res_valid, out, 1, one-cycle pulse on every commit.
- busy, out, 1, high while the FSM is not IDLE.

Function
REQ-004 An operation is accepted on a rising edge where op_valid=1 and op_ready=1.

REQ-005 op_ready is 1 only in IDLE.

REQ-006 The commit value f(x) is computed in this order:
- if op_clr=1, f = 0;
- else if mant=0, f = 0 (canonical zero);
- else if op_neg=1, f = {1'b0, x[W-2:0]};
- else f = x.

REQ-007 Single-cycle accept (op_mc=0 or op_clr=1):
- bank[op_sel] <= f(op_data) on the accepting edge;
- res_valid=1 for the following cycle;
- the FSM stays in IDLE.

REQ-008 Multicycle accept (op_mc=1 and op_clr=0):
- latch op_sel, op_data and op_neg;
- enter WAIT with cnt=MCLAT-1;
- the inputs are ignored until commit.

REQ-009 In WAIT, cnt decrements each clock. When cnt reaches 1, the next state is COMMIT.

REQ-010 COMMIT lasts exactly one cycle:
- bank[latched sel] <= f(latched data);
- return to IDLE.

REQ-011 The multicycle commit edge occurs exactly MCLAT clocks after the accepting edge. op_ready returns to 1 in the cycle after the commit.

REQ-012 The FSM has exactly the states IDLE, WAIT and COMMIT. Any unused encoding goes to IDLE.

REQ-013 op_clr=1 with op_mc=1 is treated as a single-cycle clear (op_clr has priority).

REQ-014 wr_data is the value being written on the current edge, and is 0 when no commit occurs this cycle. acc_lsb = wr_data[0].

REQ-015 rd_data reflects bank[rd_sel] as it stands before the current edge; there is no write bypass.

REQ-016 If rd_sel or op_sel is ≥ NACC:
- reads return 0;
- writes are dropped, but res_valid still pulses.

REQ-017 op_valid asserted while op_ready=0 has no effect. The requester must hold op_valid until acceptance.

REQ-018 Channels other than the target are never modified by an operation.

Reset
REQ-019 While rst=1 at a rising edge:
- all banks <= 0;
- FSM <= IDLE; cnt <= 0;
- res_valid <= 0; latched fields <= 0.

REQ-020 Reset applied during WAIT or COMMIT aborts the pending operation, and no commit occurs.

REQ-021 In the first cycle after reset deassertion:
- op_ready=1, busy=0;
- rd_data=0, wr_data=0, acc_lsb=0, res_valid=0.

Verification
REQ-022 Single-cycle write, defaults (W=23): op_valid=1, op_sel=2, op_data=23'h0A_8001, op_mc=0, op_neg=0 → on that cycle wr_data=23'h0A_8001 and acc_lsb=1; next cycle bank2=23'h0A_8001 and res_valid=1 for one cycle.

REQ-023 Force-positive: op_sel=1, op_data=23'h4A_8000, op_neg=1 → bank1=23'h0A_8000. Same op_data with op_neg=0 → bank1=23'h4A_8000.

REQ-024 Multicycle, MCLAT=3: accept at edge k with op_sel=3, op_data=23'h01_0003, op_mc=1; inputs toggled randomly meanwhile →
- op_ready=0 and busy=1 from k to k+3;
- bank3=23'h01_0003 at edge k+3;
- res_valid high in cycle k+3 only;
- op_ready=1 again after k+3.

REQ-025 Priority and zero: op_clr=1 with op_mc=1 on channel 0 (previously 23'h12_3456) → bank0=0 after one edge and no WAIT. op_data=23'h7F_0000 (mant=0) → committed 0.

REQ-026 Reset mid-operation: multicycle op accepted, rst=1 one cycle later → no commit, all banks 0, op_ready=1 the cycle after rst falls.

REQ-027 Out-of-range, NACC=3: op_sel=3 write → banks 0–2 unchanged, res_valid pulses; rd_sel=3 → rd_data=0.
